craps_engine: RTL and testbench

CRAPS_ENGINE -- requirements
Module: craps_engine

---
 rtl/craps_engine.sv | 152 +++++++++++++++
 tb/tb_craps_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/craps_engine.sv
// Craps game engine: free-running dice, synchronized roll capture, one-cycle-later
// evaluation of come-out/point rules, and saturating win/loss tallies.
//
//   state    | meaning
//   COME_OUT | no point established, next roll is a come-out roll
//   POINT_ST | point established, rolling for point or seven-out
//   WON      | last game won; next roll starts a new come-out
//   LOST     | last game lost; next roll starts a new come-out
module craps_engine #(
    parameter  int SIDES = 6,
    parameter  int CNT_W = 8,
    localparam int DW    = $clog2(SIDES + 1),
    localparam int SW    = $clog2(2 * SIDES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             roll,
    input  logic             clear,
    output logic [DW-1:0]    die0,
    output logic [DW-1:0]    die1,
    output logic [SW-1:0]    sum,
    output logic [SW-1:0]    point,
    output logic             win,
    output logic             loss,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] win_count,
    output logic [CNT_W-1:0] loss_count
);

    typedef enum logic [1:0] {
        COME_OUT = 2'b00,
        POINT_ST = 2'b01,
        WON      = 2'b10,
        LOST     = 2'b11
    } state_t;

    localparam logic [DW-1:0] DIE_MAX = DW'(SIDES);
    localparam logic [DW-1:0] DIE_ONE = DW'(1);
    localparam logic [SW-1:0] NAT_A   = SW'(SIDES + 1);
    localparam logic [SW-1:0] NAT_B   = SW'(2 * SIDES - 1);
    localparam logic [SW-1:0] CRAPS_2 = SW'(2);
    localparam logic [SW-1:0] CRAPS_3 = SW'(3);
    localparam logic [SW-1:0] CRAPS_H = SW'(2 * SIDES);

    state_t          state_q;
    state_t          nxt_state;
    logic [SW-1:0]   nxt_point;
    logic [DW-1:0]   held0;
    logic [DW-1:0]   held1;
    logic            eval_pending;
    logic            roll_s1;
    logic            roll_s2;
    logic            roll_s3;
    logic            roll_pulse;

    assign state      = state_q;
    assign roll_pulse = roll_s2 & ~roll_s3;
    assign sum        = SW'(held0) + SW'(held1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            roll_s1 <= 1'b0;
            roll_s2 <= 1'b0;
            roll_s3 <= 1'b0;
        end else begin
            roll_s1 <= roll;
            roll_s2 <= roll_s1;
            roll_s3 <= roll_s2;
        end
    end

    // die1 advances only on the cycle die0 wraps, so the pair walks all SIDES^2 combos
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            die0 <= DIE_ONE;
            die1 <= DIE_ONE;
        end else if (die0 == DIE_MAX) begin
            die0 <= DIE_ONE;
            die1 <= (die1 == DIE_MAX) ? DIE_ONE : die1 + DIE_ONE;
        end else begin
            die0 <= die0 + DIE_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            held0        <= '0;
            held1        <= '0;
            eval_pending <= 1'b0;
        end else if (eval_pending) begin
            eval_pending <= 1'b0;
        end else if (roll_pulse) begin
            held0        <= die0;
            held1        <= die1;
            eval_pending <= 1'b1;
        end
    end

    always_comb begin
        nxt_state = state_q;
        nxt_point = point;
        if (state_q == POINT_ST) begin
            if (sum == point) begin
                nxt_state = WON;
                nxt_point = '0;
            end else if (sum == NAT_A) begin
                nxt_state = LOST;
                nxt_point = '0;
            end
        end else begin
            // COME_OUT, WON and LOST all judge the roll as a fresh come-out
            if (sum == NAT_A || sum == NAT_B) begin
                nxt_state = WON;
                nxt_point = '0;
            end else if (sum == CRAPS_2 || sum == CRAPS_3 || sum == CRAPS_H) begin
                nxt_state = LOST;
                nxt_point = '0;
            end else begin
                nxt_state = POINT_ST;
                nxt_point = sum;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= COME_OUT;
            point      <= '0;
            win        <= 1'b0;
            loss       <= 1'b0;
            win_count  <= '0;
            loss_count <= '0;
        end else begin
            if (eval_pending) begin
                state_q <= nxt_state;
                point   <= nxt_point;
                win     <= (nxt_state == WON);
                loss    <= (nxt_state == LOST);
            end
            if (clear) begin
                win_count  <= '0;
                loss_count <= '0;
            end else if (eval_pending) begin
                if (nxt_state == WON && win_count != '1)
                    win_count <= win_count + 1'b1;
                if (nxt_state == LOST && loss_count != '1)
                    loss_count <= loss_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_craps_engine.sv
// Directed bench for craps_engine: dice sequence, natural/point/seven-out games,
// restart from WON, clear priority, roll glitches and reset during evaluation.
module tb_craps_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       roll  = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] die0;
    logic [2:0] die1;
    logic [3:0] sum;
    logic [3:0] point;
    logic       win;
    logic       loss;
    logic [1:0] state;
    logic [7:0] win_count;
    logic [7:0] loss_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    craps_engine dut (
        .clock      (clock),
        .reset      (reset),
        .roll       (roll),
        .clear      (clear),
        .die0       (die0),
        .die1       (die1),
        .sum        (sum),
        .point      (point),
        .win        (win),
        .loss       (loss),
        .state      (state),
        .win_count  (win_count),
        .loss_count (loss_count)
    );

    always #5 clock = ~clock;

    // clock edges seen since reset was released
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int f0(input int k);
        return (k % 6) + 1;
    endfunction

    function automatic int f1(input int k);
        return ((k / 6) % 6) + 1;
    endfunction

    function automatic int come_out_state(input int s);
        if (s == 7 || s == 11)           return 2;
        if (s == 2 || s == 3 || s == 12) return 3;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        roll  = 1'b0;
        clear = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_die0", die0, 1);
        chk("rst_die1", die1, 1);
        chk("rst_sum", sum, 0);
        chk("rst_point", point, 0);
        chk("rst_wl", {win, loss}, 0);
        chk("rst_state", state, 0);
        chk("rst_cnt", {win_count, loss_count}, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("first_die0", die0, 2);
        chk("first_die1", die1, 1);
    endtask

    // raise roll so the capture edge samples the pair (a,b); return at the negedge after capture
    task automatic capture(input int a, input int b);
        bit found = 0;
        for (int i = 0; i < 80; i++) begin
            if (f0(cyc + 2) == a && f1(cyc + 2) == b) begin
                found = 1;
                break;
            end
            @(negedge clock);
        end
        chk("pair_found", found, 1);
        roll = 1'b1;
        repeat (3) @(negedge clock);
        chk("cap_sum", sum, a + b);
    endtask

    task automatic finish_eval(input bit clr, input int st, input int pt, input int wc, input int lc);
        clear = clr;
        @(negedge clock);
        clear = 1'b0;
        chk("ev_state", state, st);
        chk("ev_point", point, pt);
        chk("ev_win", win, (st == 2) ? 1 : 0);
        chk("ev_loss", loss, (st == 3) ? 1 : 0);
        chk("ev_wcnt", win_count, wc);
        chk("ev_lcnt", loss_count, lc);
        roll = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int c;
        int gsum;

        // reset values and the 36-clock dice walk
        do_reset();
        for (int k = 0; k < 36; k++) begin
            @(negedge clock);
            chk("seq_die0", die0, f0(k + 2));
            chk("seq_die1", die1, f1(k + 2));
        end
        chk("seq_cyc", cyc, 37);

        // natural win, restart into craps, then clear on an increment edge
        do_reset();
        capture(3, 4);
        finish_eval(0, 2, 0, 1, 0);
        capture(1, 1);
        finish_eval(0, 3, 0, 1, 1);
        capture(6, 5);
        finish_eval(1, 2, 0, 0, 0);

        // point made after a non-deciding roll and a craps value during point
        do_reset();
        capture(2, 2);
        finish_eval(0, 1, 4, 0, 0);
        capture(5, 1);
        finish_eval(0, 1, 4, 0, 0);
        capture(1, 1);
        finish_eval(0, 1, 4, 0, 0);
        capture(3, 1);
        finish_eval(0, 2, 0, 1, 0);

        // seven-out
        do_reset();
        capture(6, 4);
        finish_eval(0, 1, 10, 0, 0);
        capture(6, 1);
        finish_eval(0, 3, 0, 0, 1);

        // glitch entirely between clock edges is never seen
        do_reset();
        @(negedge clock);
        #1 roll = 1'b1;
        #2 roll = 1'b0;
        repeat (5) @(negedge clock);
        chk("glitch0_sum", sum, 0);
        chk("glitch0_state", state, 0);

        // glitch straddling one rising edge yields exactly one capture
        c = cyc;
        #3 roll = 1'b1;
        #4 roll = 1'b0;
        repeat (3) @(negedge clock);
        gsum = f0(c + 2) + f1(c + 2);
        chk("glitch1_sum", sum, gsum);
        @(negedge clock);
        chk("glitch1_state", state, come_out_state(gsum));
        chk("glitch1_point", point, (come_out_state(gsum) == 1) ? gsum : 0);
        repeat (6) @(negedge clock);
        chk("glitch1_hold", sum, gsum);

        // reset between capture and evaluation abandons the game
        do_reset();
        capture(3, 4);
        reset = 1'b0;
        #1;
        chk("midrst_state", state, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_wl", {win, loss}, 0);
        chk("midrst_die", {die0, die1}, 6'o11);
        roll = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("midrst_after_state", state, 0);
        chk("midrst_after_cnt", {win_count, loss_count}, 0);
        chk("midrst_after_point", point, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
